// File: rtl/data_sram_responder.sv
// data_sram_responder
//
// Responder for the core's data-SRAM request port. The execute stage presents
// one request per cycle on en/we/addr/wdata; this block stores words with
// byte-lane enables and returns load data a fixed READ_LATENCY cycles after
// the request edge. It also keeps saturating load/store counters and flags
// out-of-range accesses.
//
// Parameters
//   ADDR_WIDTH    byte-address bits decoded; storage is 2^(ADDR_WIDTH-2) words
//   READ_LATENCY  request edge to data_sram_rdata valid, 1..4 cycles
//
// Ports
//   clk              clock
//   reset            synchronous, active-high reset
//   data_sram_en     request strobe
//   data_sram_we     byte write enables; 4'b0000 with en=1 is a load
//   data_sram_addr   byte address, bits [1:0] ignored for indexing
//   data_sram_wdata  lane-replicated write data
//   data_sram_rdata  load data, holds its last value while rdata_valid=0
//   rdata_valid      one-cycle pulse per completed load
//   addr_err         pulse aligned with the response of an out-of-range access
//   load_cnt         accepted loads, saturating
//   store_cnt        accepted stores, saturating
//   misalign_err     sticky illegal-byte-enable flag
//
// Optional feature macro: DATA_SRAM_MISALIGN_CHK_EN
//   Defined:   only 0001/0010/0100/1000/0011/1100/1111 are legal store enables;
//              other nonzero patterns are dropped and set misalign_err.
//   Undefined: every nonzero enable pattern is written; misalign_err is 0.

module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic        misalign_err
);

  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned Words = 2 ** IdxW;
  localparam int unsigned Last  = READ_LATENCY - 1;

  // Elaboration-time parameter checks.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("data_sram_responder: READ_LATENCY must be in 1..4");
  end
  if (ADDR_WIDTH < 3 || ADDR_WIDTH > 31) begin : g_bad_addr_width
    $error("data_sram_responder: ADDR_WIDTH must be in 3..31");
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic            in_range;
  logic [IdxW-1:0] word_idx;
  logic            is_load;
  logic            is_store;
  logic            we_legal;
  logic            store_ok;
  logic            wr_en;
  logic            unused_addr_lsb;

  assign in_range        = (data_sram_addr >> ADDR_WIDTH) == 32'd0;
  assign word_idx        = data_sram_addr[ADDR_WIDTH-1:2];
  assign is_load         = data_sram_en && (data_sram_we == 4'b0000);
  assign is_store        = data_sram_en && (data_sram_we != 4'b0000);
  assign store_ok        = is_store && we_legal;
  assign wr_en           = store_ok && in_range && !reset;
  assign unused_addr_lsb = ^data_sram_addr[1:0];

`ifdef DATA_SRAM_MISALIGN_CHK_EN
  logic misalign_q;

  always_comb begin
    we_legal = 1'b0;
    unique case (data_sram_we)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: we_legal = 1'b1;
      default:                   we_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (is_store && !we_legal) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign we_legal     = 1'b1;
  assign misalign_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Storage: no reset, byte-lane writes
  // ---------------------------------------------------------------------------
  logic [31:0] mem [Words];
  logic [31:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = mem[word_idx];

  // ---------------------------------------------------------------------------
  // Load latency pipeline. Stage 0 captures the array read at the request
  // edge; later stages only move data when a valid entry advances, so the
  // last stage naturally holds the previous response between loads.
  // ---------------------------------------------------------------------------
  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] err_q;
  logic [31:0]             data_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= is_load;
      if (is_load) begin
        data_q[0] <= in_range ? rd_word : 32'd0;
        err_q[0]  <= !in_range;
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          err_q[i]  <= err_q[i-1];
        end
      end
    end
  end

  // Out-of-range store error always reports one cycle after the request,
  // independent of READ_LATENCY.
  logic store_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      store_err_q <= 1'b0;
    end else begin
      store_err_q <= store_ok && !in_range;
    end
  end

  assign rdata_valid     = vld_q[Last];
  assign data_sram_rdata = data_q[Last];
  assign addr_err        = (vld_q[Last] && err_q[Last]) || store_err_q;

  // ---------------------------------------------------------------------------
  // Saturating request counters
  // ---------------------------------------------------------------------------
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (is_load && load_cnt_q != 32'hFFFF_FFFF) begin
      load_cnt_d = load_cnt_q + 32'd1;
    end
    if (store_ok && store_cnt_q != 32'hFFFF_FFFF) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: four instances (READ_LATENCY 1..4) share one
// request stream; a transaction-level model predicts every output each cycle.
module tb_data_sram_responder;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic [3:0]  we    = 4'b0;
  logic [31:0] addr  = 32'b0;
  logic [31:0] wdata = 32'b0;

  logic [31:0] rdata [NI];
  logic        rv    [NI];
  logic        aerr  [NI];
  logic [31:0] lcnt  [NI];
  logic [31:0] scnt  [NI];
  logic        merr  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_sram_responder #(
      .ADDR_WIDTH  (12),
      .READ_LATENCY(g + 1)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .data_sram_en   (en),
      .data_sram_we   (we),
      .data_sram_addr (addr),
      .data_sram_wdata(wdata),
      .data_sram_rdata(rdata[g]),
      .rdata_valid    (rv[g]),
      .addr_err       (aerr[g]),
      .load_cnt       (lcnt[g]),
      .store_cnt      (scnt[g]),
      .misalign_err   (merr[g])
    );
  end

  // Reference model: a word map, a list of issued loads and plain counters.
  typedef struct {
    int          issue;
    logic [31:0] data;
    bit          err;
  } resp_t;

  logic [31:0] ref_mem [int];
  resp_t       loads [$];
  logic [31:0] m_lc, m_sc;
  bit          m_merr;
  bit          m_st_err;
  logic [31:0] last_data [NI];
  bit          exp_v [NI];
  bit          exp_e [NI];
  int          cyc = 0;

  int compared   = 0;
  int mismatched = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit          inr;
    int          idx;
    bit          legal;
    logic [31:0] m;
    resp_t       r;
    m_st_err = 1'b0;
    if (reset) begin
      loads.delete();
      m_lc   = '0;
      m_sc   = '0;
      m_merr = 1'b0;
      for (int k = 0; k < NI; k++) last_data[k] = '0;
    end else if (en) begin
      inr = (addr >> 12) == 0;
      idx = int'(addr[11:2]);
      if (we != 4'b0) begin
        legal = 1'b1;
`ifdef DATA_SRAM_MISALIGN_CHK_EN
        legal = we inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        if (!legal) m_merr = 1'b1;
`endif
        if (legal) begin
          if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
          m_st_err = !inr;
          if (inr) begin
            m = ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;
            for (int i = 0; i < 4; i++) if (we[i]) m[8*i +: 8] = wdata[8*i +: 8];
            ref_mem[idx] = m;
          end
        end
      end else begin
        if (m_lc != 32'hFFFF_FFFF) m_lc = m_lc + 1;
        r.issue = cyc;
        r.data  = inr ? ref_mem[idx] : 32'h0;
        r.err   = !inr;
        loads.push_back(r);
      end
    end
    // A load issued at edge t appears on the latency-L instance after edge t+L-1.
    for (int k = 0; k < NI; k++) begin
      exp_v[k] = 1'b0;
      exp_e[k] = 1'b0;
      foreach (loads[j]) begin
        if (loads[j].issue == cyc - k) begin
          exp_v[k]     = 1'b1;
          exp_e[k]     = loads[j].err;
          last_data[k] = loads[j].data;
        end
      end
    end
    while (loads.size() > 0 && loads[0].issue <= cyc - (NI - 1)) void'(loads.pop_front());
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check32($sformatf("L%0d rdata_valid", k + 1), {31'b0, rv[k]}, {31'b0, exp_v[k]});
      check32($sformatf("L%0d rdata", k + 1), rdata[k], last_data[k]);
      check32($sformatf("L%0d addr_err", k + 1), {31'b0, aerr[k]},
              {31'b0, m_st_err | (exp_v[k] & exp_e[k])});
      check32($sformatf("L%0d load_cnt", k + 1), lcnt[k], m_lc);
      check32($sformatf("L%0d store_cnt", k + 1), scnt[k], m_sc);
      check32($sformatf("L%0d misalign_err", k + 1), {31'b0, merr[k]}, {31'b0, m_merr});
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    reset = r;
    en    = e;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom, $urandom);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;

    // Reset state.
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 4'hF, 32'h10, 32'h1);
    check32("reset rdata", rdata[0], 32'h0);
    check32("reset load_cnt", lcnt[0], 32'h0);

    // Word store then load, latency 1.
    step(1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 4'b0000, 32'h10, 32'h0);
    check32("word rdata_valid", {31'b0, rv[0]}, 32'd1);
    check32("word rdata", rdata[0], 32'hDEAD_BEEF);
    check32("word store_cnt", scnt[0], 32'd1);
    check32("word load_cnt", lcnt[0], 32'd1);
    idle(4);

    // Byte and half-word lanes.
    step(1'b0, 1'b1, 4'b0010, 32'h11, 32'h0000_AA00);
    step(1'b0, 1'b1, 4'b1100, 32'h12, 32'h5566_0000);
    step(1'b0, 1'b1, 4'b0000, 32'h10, 32'h0);
    check32("lanes rdata", rdata[0], 32'h5566_AAEF);
    idle(4);

    // Back-to-back loads; latency-3 instance returns them on consecutive cycles.
    step(1'b0, 1'b1, 4'b1111, 32'h0, 32'h0BAD_F00D);
    step(1'b0, 1'b1, 4'b1111, 32'h4, 32'h1357_9BDF);
    step(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
    step(1'b0, 1'b1, 4'b0000, 32'h4, 32'h0);
    step(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
    check32("b2b first rdata", rdata[2], 32'h0BAD_F00D);
    step(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    check32("b2b second rdata", rdata[2], 32'h1357_9BDF);
    idle(4);

    // Out-of-range store and load.
    step(1'b0, 1'b1, 4'b1111, 32'h1000, 32'h1234_5678);
    check32("oor store addr_err", {31'b0, aerr[0]}, 32'd1);
    step(1'b0, 1'b1, 4'b0000, 32'h1000, 32'h0);
    check32("oor load addr_err", {31'b0, aerr[0]}, 32'd1);
    check32("oor load rdata", rdata[0], 32'h0);
    step(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
    check32("oor word0 intact", rdata[0], 32'h0BAD_F00D);
    idle(4);

    // Reset while loads are in flight.
    step(1'b0, 1'b1, 4'b0000, 32'h4, 32'h0);
    step(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
    idle(5);
    check32("midreset load_cnt", lcnt[1], 32'h0);
    check32("midreset store_cnt", scnt[1], 32'h0);

    // Non-contiguous byte enables.
    step(1'b0, 1'b1, 4'b1111, 32'h20, 32'hA1B2_C3D4);
    step(1'b0, 1'b1, 4'b0110, 32'h20, 32'h9988_7766);
    step(1'b0, 1'b1, 4'b0000, 32'h20, 32'h0);
`ifdef DATA_SRAM_MISALIGN_CHK_EN
    check32("misalign rdata", rdata[0], 32'hA1B2_C3D4);
    check32("misalign flag", {31'b0, merr[0]}, 32'd1);
`else
    check32("misalign rdata", rdata[0], 32'hA188_77D4);
    check32("misalign flag", {31'b0, merr[0]}, 32'd0);
`endif
    idle(4);

    // Fill words 0..15 so every random load returns defined data.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:12] == 20'h0) a[12] = 1'b1;
      end else begin
        a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      end
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 6) != 0, w, a, $urandom);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder side of the core's data-SRAM request interface. The execute stage drives en/we/addr/wdata; this block answers.
- Provides word-organised on-chip data storage with byte-lane writes.
- Returns load data after a fixed, parameterised read latency, aligned to the memory stage.
- Keeps saturating load/store counters and flags out-of-range accesses.

Parameters:
- ADDR_WIDTH, 12: byte-address bits decoded. Storage holds 2^(ADDR_WIDTH-2) 32-bit words.
- READ_LATENCY, 1: cycles from request edge to data_sram_rdata valid. Legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- data_sram_en  in  1  request strobe, sampled every posedge.
- data_sram_we  in  4  byte write enables. 4'b0000 with en=1 means load.
- data_sram_addr  in  32  byte address. Bits [1:0] are ignored for indexing.
- data_sram_wdata  in  32  write data, already lane-replicated by the requester.
- data_sram_rdata  out  32  load data.
- rdata_valid  out  1  pulse marking data_sram_rdata valid for one load.
- addr_err  out  1  pulse aligned with the response of an out-of-range access.
- load_cnt  out  32  accepted loads, saturating.
- store_cnt  out  32  accepted stores, saturating.
- misalign_err  out  1  sticky illegal-byte-enable flag (optional feature).

Behaviour:
- Reset (synchronous, active-high, clk):
  - rdata_valid=0, data_sram_rdata=0, addr_err=0, load_cnt=0, store_cnt=0, misalign_err=0.
  - All in-flight latency stages are cleared.
  - Storage contents are not reset; a read of an unwritten word returns X in simulation.
- Request classification at each posedge with en=1:
  - we!=0: store.
  - we==0: load.
  - en=0: no action; we/addr/wdata are don't-care.
- Range check:
  - In range when addr[31:ADDR_WIDTH]==0.
  - Out-of-range store: write suppressed, store_cnt still increments, addr_err pulses one cycle after the request edge.
  - Out-of-range load: response data forced to 0, addr_err pulses together with rdata_valid.
- Store:
  - At the request edge, word addr[ADDR_WIDTH-1:2] updates lane i (bits 8i+7:8i) from wdata where we[i]=1. Other lanes are unchanged.
  - Stores produce no rdata_valid.
- Load:
  - The array is read at the request edge into latency stage 1.
  - Stages 2..READ_LATENCY form a valid+data+err shift register.
  - rdata_valid, data_sram_rdata and addr_err come from the last stage, so they are valid READ_LATENCY cycles after the request edge.
  - One load per cycle; fully pipelined, no backpressure.
- Response hold: data_sram_rdata holds its last value when rdata_valid=0. Consumers must qualify with rdata_valid.
- Read/write ordering:
  - A load in the cycle after a store to the same word returns the new data.
  - Load and store cannot occur in the same cycle; en carries one request.
- Counters:
  - +1 per accepted request of the matching class.
  - Saturate at 32'hFFFF_FFFF (no wrap).
- Reset mid-operation: loads in flight are discarded. No rdata_valid appears after reset deasserts until a new load completes its latency.
- READ_LATENCY outside 1..4: elaboration error via generate-time check.

Optional Feature:
- Macro: DATA_SRAM_MISALIGN_CHK_EN.
- Defined:
  - Legal store enables are 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111.
  - Any other nonzero we with en=1 suppresses the write, does not increment store_cnt, and sets misalign_err on the next edge.
  - misalign_err stays set until reset.
- Undefined: every nonzero we pattern is written as given, and misalign_err is tied to 0.

Test Plan:
- Word store/load, READ_LATENCY=1: store addr 0x10, we 1111, wdata 0xDEADBEEF; next cycle load 0x10 -> next cycle rdata_valid=1, rdata=0xDEADBEEF, store_cnt=1, load_cnt=1.
- Byte/half lanes: after the word above, store addr 0x11 we 0010 wdata 0x0000AA00, then addr 0x12 we 1100 wdata 0x55660000; load 0x10 -> rdata=0x5566AAEF.
- Latency/back-to-back, READ_LATENCY=3: preload words 0x0 and 0x4; issue loads 0x0, 0x4, 0x0 on consecutive cycles -> rdata_valid high on cycles 3, 4, 5 after the first request, data in request order, no gaps.
- Out-of-range (ADDR_WIDTH=12): store 0x1000 wdata 0x12345678 then load 0x1000 -> addr_err pulses for both, load rdata=0, word 0x000 unchanged.
- Reset mid-flight, READ_LATENCY=2: issue load, assert reset next cycle for 1 cycle -> rdata_valid never pulses, counters=0.
- Misalign (macro on): store we 0110 to 0x20 -> misalign_err=1 sticky, word 0x20 unchanged, store_cnt unchanged. Macro off: lanes 1-2 written.
